// File: rtl/shift_in4.sv
// 4-bit serial-in/parallel-out shift register with a modulo-4 frame counter
// and a one-cycle valid strobe marking each completed nibble.

module dffe (
  input  logic clk,
  input  logic en,
  input  logic d,
  output logic q
);

  // Edge-captured storage bit, updated only when enabled
  always_ff @(posedge clk) begin
    if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

module shift_in4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       dIn,
  input  logic       shiftEn,
  output logic [3:0] q,
  output logic       valid,
  output logic [1:0] count
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } frameState_e;

  frameState_e stateR;
  frameState_e stateNextS;
  logic        validNextS;
  logic [3:0]  qDS;
  logic        qEnS;

  // Reset is folded into the storage bits' data/enable so it stays synchronous
  assign qEnS = reset | shiftEn;
  assign qDS  = reset ? 4'b0000 : {q[2:0], dIn};

  genvar i;
  generate
    for (i = 0; i < 4; i = i + 1) begin : gBit
      dffe uBit (
        .clk (clk),
        .en  (qEnS),
        .d   (qDS[i]),
        .q   (q[i])
      );
    end
  endgenerate

  // Frame counter next state; the S3 -> S0 step completes a frame
  always_comb begin
    stateNextS = stateR;
    validNextS = 1'b0;
    if (shiftEn) begin
      case (stateR)
        S0: begin
          stateNextS = S1;
          validNextS = 1'b0;
        end
        S1: begin
          stateNextS = S2;
          validNextS = 1'b0;
        end
        S2: begin
          stateNextS = S3;
          validNextS = 1'b0;
        end
        S3: begin
          stateNextS = S0;
          validNextS = 1'b1;
        end
        default: begin
          stateNextS = S0;
          validNextS = 1'b0;
        end
      endcase
    end else begin
      stateNextS = stateR;
      validNextS = 1'b0;
    end
  end

  // Counter state and strobe registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= S0;
      valid  <= 1'b0;
    end else begin
      stateR <= stateNextS;
      valid  <= validNextS;
    end
  end

  assign count = stateR;

endmodule

// File: doc/shift_in4.md
# shift_in4

4-bit serial-in/parallel-out shift register with a frame counter and one-cycle `valid` strobe. It sits directly downstream of the single-bit enable flip-flop (`DFFE`). It takes the same serial `dIn` / enable pairing and assembles four consecutive enabled bits into a nibble for the next stage. Storage bits are `DFFE` instances plus glue gates; the block adds synchronous reset, a 2-bit modulo-4 counter and the strobe.

## Interface
- Parameters: none (width fixed at 4; counter fixed at 2 bits).
- `clk`  input  1  single clock; all state changes on rising edge only.
- `reset`  input  1  synchronous, active-high; sampled on rising `clk`.
- `dIn`  input  1  serial data bit.
- `shiftEn`  input  1  high = shift `dIn` in on this edge; low = hold.
- `q`  output  4  assembled nibble; `q[3]` = oldest bit, `q[0]` = newest.
- `valid`  output  1  one-cycle strobe; `q` holds a complete 4-bit frame.
- `count`  output  2  number of bits received in the current frame (0..3).

## Operation
- One clock; reset is synchronous and active-high. Clock port is `clk`, reset port is `reset`.
- Every rising edge evaluates in priority order:
  1. `reset`=1: `q`<=0000, `count`<=00, `valid`<=0. `shiftEn` and `dIn` are ignored.
  2. `shiftEn`=1:
     - `q` <= {`q[2:0]`, `dIn`}
     - `count` <= `count`+1 mod 4 (3 wraps to 0, no carry out)
     - `valid` <= 1 if `count` was 3, else 0
  3. `shiftEn`=0: `q` and `count` hold; `valid`<=0.
- Counter states S0..S3 equal `count`. Transition S_n to S_(n+1 mod 4) only on enabled edges. The S3 to S0 transition raises `valid`.
- `valid` is registered and high for exactly one cycle per frame. It is never held, even if `shiftEn` then stays low.
- Frames are back-to-back: a 5th enabled bit starts the next frame in the same edge that `valid` falls. No idle cycle is required.
- `q` is not cleared between frames. Mid-frame `q` contents are defined: the last 4 shifted bits. Consumers use `q` only while `valid`=1.
- `dIn` and `shiftEn` must be stable around the rising edge. No latching behaviour while `clk` is high: the enable gating feeds edge-captured bits only.

## Timing
- Power-on state is undefined until the first `reset` edge. After that: `q`=0000, `count`=0, `valid`=0.
- Latency: a bit presented at edge k appears in `q[0]` after edge k. It reaches `q[3]` after 3 further enabled edges.
- `valid` rises after the edge that captures the 4th bit, coincident with `q` holding the full frame. It falls after the next edge.
- Reset mid-frame: the partial frame is discarded and `count` returns to 0. If reset coincides with the 4th bit, `valid` stays 0 and no frame is reported.
- `shiftEn` gaps of any length inside a frame are allowed; the frame completes on the 4th enabled edge.
- Outputs change only after rising `clk`, never combinationally from inputs.

## Test plan
- Basic frame: `reset`=1 for one edge, then `shiftEn`=1 with `dIn`=1,0,1,1 on edges 1-4. Required:
  - `q`=1011 and `valid`=1 after edge 4.
  - `valid`=0 after edge 5 when `shiftEn`=0.
  - `q` stays 1011.
- Gapped frame: bits 0,1,1,0 with `shiftEn`=0 for 2 edges between bits 2 and 3. Required: `count` holds at 2 across the gap; `valid` pulses only after the 4th enabled edge, with `q`=0110.
- Back-to-back: 8 consecutive enabled bits 1,1,0,0,0,0,1,1. Required:
  - `valid`=1 after edge 4 with `q`=1100, then 0 after edge 5.
  - `valid`=1 after edge 8 with `q`=0011.
  - `count` sequence 1,2,3,0,1,2,3,0.
- Reset mid-frame: shift 1,1, then `reset`=1 with `shiftEn`=1 on the same edge, then shift 0,1,0,1. Required:
  - `q`=0000 and `count`=0 after the reset edge.
  - A single `valid` pulse with `q`=0101, 4 edges after reset.
- Reset on 4th bit: shift 1,0,0 and assert `reset` on the 4th enabled edge. Required: `valid` never rises, `q`=0000, `count`=0.
